// File: rtl/ref_fifo_drain_arbiter.sv
// Round-robin drain scheduler for several look-ahead FIFO read sides.
// Grants one channel at a time and pops a burst of up to MAX_BURST words
// into a single registered valid/ready stream tagged with channel and
// end-of-burst. Everything runs in the FIFO read clock domain.
module ref_fifo_drain_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int CH_WIDTH    = 2,
  parameter int DATA_WIDTH  = 72,
  parameter int LEVEL_WIDTH = 8,
  parameter int MAX_BURST   = 16,
  parameter int BURST_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             ch_mask,
  input  logic [NUM_CH-1:0]             fifo_empty,
  input  logic [NUM_CH*LEVEL_WIDTH-1:0] fifo_level,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  fifo_data,
  output logic [NUM_CH-1:0]             fifo_ack,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CH_WIDTH-1:0]           out_ch,
  output logic                          out_last,
  output logic                          busy,
  output logic                          burst_abort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  // Wide enough to hold last_grant + 1 + offset before the modulo fold.
  localparam int IW = CH_WIDTH + 2;

  state_t                  state_reg, state_next;
  logic [CH_WIDTH-1:0]     grant_reg, grant_next;
  logic [CH_WIDTH-1:0]     last_grant_reg, last_grant_next;
  logic [BURST_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [BURST_WIDTH-1:0]  burst_len_reg, burst_len_next;
  logic                    out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
  logic [CH_WIDTH-1:0]     out_ch_reg, out_ch_next;
  logic                    out_last_reg, out_last_next;
  logic                    abort_reg, abort_next;

  // Per-channel views of the packed FIFO buses.
  logic [LEVEL_WIDTH-1:0]  level_arr [NUM_CH];
  logic [DATA_WIDTH-1:0]   data_arr  [NUM_CH];

  // Round-robin search: candidate gi is the channel gi+1 places after
  // the previous grant, so candidate 0 has the highest priority.
  logic [NUM_CH-1:0]       req;
  logic [IW-1:0]           cand_sum [NUM_CH];
  logic [CH_WIDTH-1:0]     cand_idx [NUM_CH];
  logic [NUM_CH-1:0]       cand_req;

  logic                    found;
  logic [CH_WIDTH-1:0]     winner;
  logic [LEVEL_WIDTH-1:0]  winner_level;
  logic [BURST_WIDTH-1:0]  win_burst;

  logic                    grant_empty;
  logic [DATA_WIDTH-1:0]   grant_data;
  logic                    pop;
  logic                    last_word;

  assign req = ~fifo_empty & ch_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign level_arr[gi] = fifo_level[gi*LEVEL_WIDTH +: LEVEL_WIDTH];
      assign data_arr[gi]  = fifo_data[gi*DATA_WIDTH +: DATA_WIDTH];

      // Sum never reaches 2*NUM_CH, so one conditional subtract is the modulo.
      assign cand_sum[gi] = IW'(last_grant_reg) + IW'(gi + 1);
      assign cand_idx[gi] = (cand_sum[gi] >= IW'(NUM_CH))
                          ? CH_WIDTH'(cand_sum[gi] - IW'(NUM_CH))
                          : CH_WIDTH'(cand_sum[gi]);
      assign cand_req[gi] = req[cand_idx[gi]];

      // Only the granted channel can be acked, and only on a pop.
      assign fifo_ack[gi] = pop & (grant_reg == CH_WIDTH'(gi));
    end
  endgenerate

  // Pick the first requesting candidate in round-robin order.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        found  = 1'b1;
        winner = cand_idx[k];
      end
    end
  end

  assign winner_level = level_arr[winner];

  // Burst length is the winner's fill level capped at MAX_BURST.
  always_comb begin
    if (32'(winner_level) >= MAX_BURST) begin
      win_burst = BURST_WIDTH'(MAX_BURST);
    end else begin
      win_burst = BURST_WIDTH'(winner_level);
    end
  end

  assign grant_empty = fifo_empty[grant_reg];
  assign grant_data  = data_arr[grant_reg];
  assign last_word   = (cnt_reg == (burst_len_reg - BURST_WIDTH'(1)));

  // A pop needs a word in the granted FIFO and room in the output register;
  // held off entirely while reset is asserted.
  assign pop = (state_reg == XFER) & ~grant_empty &
               (~out_valid_reg | out_ready) & ~rst;

  // Next-state and datapath update decisions.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    burst_len_next  = burst_len_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_ch_next     = out_ch_reg;
    out_last_next   = out_last_reg;
    abort_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = ARB;
        end
      end

      ARB: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (found) begin
          state_next      = XFER;
          grant_next      = winner;
          last_grant_next = winner;
          burst_len_next  = win_burst;
          cnt_next        = '0;
        end
      end

      XFER: begin
        if (grant_empty) begin
          // FIFO was flushed under us: drop the rest of the burst.
          abort_next = 1'b1;
          state_next = enable ? ARB : IDLE;
        end else if (pop) begin
          cnt_next = cnt_reg + BURST_WIDTH'(1);
          if (last_word) begin
            state_next = enable ? ARB : IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Output register: load on pop, otherwise drain on ready, else hold.
    if (pop) begin
      out_valid_next = 1'b1;
      out_data_next  = grant_data;
      out_ch_next    = grant_reg;
      out_last_next  = last_word;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Grant bookkeeping, burst counter and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_reg      <= '0;
      last_grant_reg <= CH_WIDTH'(NUM_CH - 1);
      cnt_reg        <= '0;
      burst_len_reg  <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_ch_reg     <= '0;
      out_last_reg   <= 1'b0;
      abort_reg      <= 1'b0;
    end else begin
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      burst_len_reg  <= burst_len_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_ch_reg     <= out_ch_next;
      out_last_reg   <= out_last_next;
      abort_reg      <= abort_next;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_ch      = out_ch_reg;
  assign out_last    = out_last_reg;
  assign burst_abort = abort_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_ref_fifo_drain_arbiter.sv
// Scoreboard bench for ref_fifo_drain_arbiter: queue-based look-ahead FIFO
// models feed the DUT, expected words are queued when stimulus is loaded,
// and a separate monitor pops and compares every accepted output word.
module tb_ref_fifo_drain_arbiter;

  localparam int NUM_CH      = 4;
  localparam int CH_WIDTH    = 2;
  localparam int DATA_WIDTH  = 72;
  localparam int LEVEL_WIDTH = 8;
  localparam int MAX_BURST   = 16;
  localparam int BURST_WIDTH = 5;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          enable = 1'b0;
  logic [NUM_CH-1:0]             ch_mask = 4'hF;
  logic [NUM_CH-1:0]             fifo_empty;
  logic [NUM_CH*LEVEL_WIDTH-1:0] fifo_level;
  logic [NUM_CH*DATA_WIDTH-1:0]  fifo_data;
  logic [NUM_CH-1:0]             fifo_ack;
  logic                          out_valid;
  logic                          out_ready = 1'b1;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [CH_WIDTH-1:0]           out_ch;
  logic                          out_last;
  logic                          busy;
  logic                          burst_abort;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] d;
    logic [CH_WIDTH-1:0]   ch;
    logic                  last;
  } exp_t;

  exp_t                  exp_q [$];
  logic [DATA_WIDTH-1:0] fq [NUM_CH][$];
  int                    checks = 0;
  int                    failures = 0;
  int                    pop_count = 0;
  int                    abort_count = 0;
  logic [NUM_CH-1:0]     ack_s = '0;

  ref_fifo_drain_arbiter #(
    .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .LEVEL_WIDTH(LEVEL_WIDTH), .MAX_BURST(MAX_BURST), .BURST_WIDTH(BURST_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .fifo_empty(fifo_empty), .fifo_level(fifo_level), .fifo_data(fifo_data),
    .fifo_ack(fifo_ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .busy(busy), .burst_abort(burst_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] mk(int t, int ch, int i);
    return {8'(t), 8'(ch), 16'(i), 8'hA5, 32'(t * 1000 + ch * 100 + i)};
  endfunction

  // Drive FIFO-side inputs from the queue models (look-ahead head word).
  task automatic refresh();
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_level[i*LEVEL_WIDTH +: LEVEL_WIDTH] = LEVEL_WIDTH'(fq[i].size());
      fifo_data[i*DATA_WIDTH +: DATA_WIDTH] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic load(int ch, int t, int first, int n);
    for (int i = 0; i < n; i++) fq[ch].push_back(mk(t, ch, first + i));
    refresh();
  endtask

  task automatic expect_words(int ch, int t, int first, int n, bit last_on_final);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d    = mk(t, ch, first + i);
      e.ch   = CH_WIDTH'(ch);
      e.last = last_on_final && (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample acks mid-cycle, then apply pops just after the edge.
  task automatic tick();
    @(negedge clk);
    ack_s = fifo_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ack_s[i]) begin
        chk("ack_nonempty", 128'(fq[i].size() > 0), 1);
        if (fq[i].size() > 0) begin
          void'(fq[i].pop_front());
          pop_count++;
        end
      end
    end
    refresh();
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 128'(exp_q.size()), 0);
  endtask

  task automatic wait_pops(string name, int target, int budget);
    int n = 0;
    while (pop_count < target && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_pops"}, 128'(pop_count), 128'(target));
  endtask

  task automatic go_idle(string name);
    enable = 1'b0;
    tick();
    tick();
    chk({name, "_idle"}, 128'(busy), 0);
  endtask

  // Monitor: scoreboard compare on every accepted word, hold checks under
  // backpressure, ack sanity and abort pulse counting.
  initial begin
    logic                  held;
    logic [DATA_WIDTH-1:0] hd;
    logic [CH_WIDTH-1:0]   hc;
    logic                  hl;
    exp_t                  e;
    held = 1'b0;
    hd = '0;
    hc = '0;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ack_in_reset", 128'(fifo_ack), 0);
        held = 1'b0;
      end else begin
        chk("ack_onehot0", 128'($onehot0(fifo_ack)), 1);
        if (held) begin
          chk("hold_valid", 128'(out_valid), 1);
          chk("hold_data", 128'(out_data), 128'(hd));
          chk("hold_ch", 128'(out_ch), 128'(hc));
          chk("hold_last", 128'(out_last), 128'(hl));
        end
        if (out_valid && !out_ready) begin
          chk("bp_no_ack", 128'(fifo_ack), 0);
        end
        if (out_valid && out_ready) begin
          $display("word ch=%0d last=%0b data=%h", out_ch, out_last, out_data);
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 128'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", 128'(out_data), 128'(e.d));
            chk("word_ch", 128'(out_ch), 128'(e.ch));
            chk("word_last", 128'(out_last), 128'(e.last));
          end
        end
        held = out_valid && !out_ready;
        hd = out_data;
        hc = out_ch;
        hl = out_last;
        if (burst_abort) abort_count++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    refresh();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 0);
    chk("rst_out_data", 128'(out_data), 0);
    chk("rst_out_ch", 128'(out_ch), 0);
    chk("rst_out_last", 128'(out_last), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_abort", 128'(burst_abort), 0);
    chk("rst_ack", 128'(fifo_ack), 0);
    rst = 1'b0;
    tick();

    // Round-robin: 4 channels x 3 words, 12 pops in 16 cycles from first ARB
    for (int c = 0; c < NUM_CH; c++) begin
      load(c, 1, 0, 3);
      expect_words(c, 1, 0, 3, 1'b1);
    end
    enable = 1'b1;
    tick();
    pop_count = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 4)  chk("rr_pops_c4", 128'(pop_count), 3);
      if (k == 5)  chk("rr_gap_c5", 128'(pop_count), 3);
      if (k == 8)  chk("rr_pops_c8", 128'(pop_count), 6);
      if (k == 16) chk("rr_pops_c16", 128'(pop_count), 12);
    end
    wait_drain("rr", 10);
    go_idle("rr");

    // Burst cap: 40 words on ch2 -> 16, 16, 8 with ARB gaps
    load(2, 2, 0, 40);
    expect_words(2, 2, 0, 16, 1'b1);
    expect_words(2, 2, 16, 16, 1'b1);
    expect_words(2, 2, 32, 8, 1'b1);
    enable = 1'b1;
    tick();
    pop_count = 0;
    repeat (17) tick();
    chk("cap_b1", 128'(pop_count), 16);
    tick();
    chk("cap_gap1", 128'(pop_count), 16);
    repeat (16) tick();
    chk("cap_b2", 128'(pop_count), 32);
    tick();
    chk("cap_gap2", 128'(pop_count), 32);
    repeat (8) tick();
    chk("cap_b3", 128'(pop_count), 40);
    wait_drain("cap", 10);
    go_idle("cap");

    // Backpressure: 5 stalled cycles in the middle of a ch1 burst
    load(1, 3, 0, 6);
    expect_words(1, 3, 0, 6, 1'b1);
    pop_count = 0;
    enable = 1'b1;
    wait_pops("bp_pre", 2, 10);
    out_ready = 1'b0;
    repeat (5) tick();
    chk("bp_stalled_pops", 128'(pop_count), 2);
    out_ready = 1'b1;
    wait_drain("bp", 20);
    chk("bp_total_pops", 128'(pop_count), 6);
    go_idle("bp");

    // Mask 1010 and enable drop mid-burst on ch3
    ch_mask = 4'b1010;
    load(0, 4, 0, 2);
    load(1, 4, 0, 2);
    load(2, 4, 0, 2);
    load(3, 4, 0, 20);
    expect_words(3, 4, 0, 16, 1'b1);
    expect_words(1, 4, 0, 2, 1'b1);
    expect_words(3, 4, 16, 4, 1'b1);
    pop_count = 0;
    enable = 1'b1;
    wait_pops("mask_pre", 20, 60);
    enable = 1'b0;
    begin
      int n = 0;
      while (busy && n < 20) begin
        tick();
        n++;
      end
    end
    chk("mask_busy_low", 128'(busy), 0);
    chk("mask_ch3_done", 128'(fq[3].size()), 0);
    chk("mask_pops", 128'(pop_count), 22);
    chk("mask_ch0_untouched", 128'(fq[0].size()), 2);
    chk("mask_ch2_untouched", 128'(fq[2].size()), 2);
    repeat (3) tick();
    chk("mask_no_ack_idle", 128'(pop_count), 22);
    wait_drain("mask", 10);
    fq[0].delete();
    fq[2].delete();
    refresh();
    ch_mask = 4'hF;

    // Abort: ch0 burst of 8 flushed after 3 pops, then ch1 served
    load(0, 5, 0, 8);
    load(1, 5, 0, 2);
    expect_words(0, 5, 0, 3, 1'b0);
    expect_words(1, 5, 0, 2, 1'b1);
    pop_count = 0;
    abort_count = 0;
    enable = 1'b1;
    wait_pops("abort_pre", 3, 10);
    fq[0].delete();
    refresh();
    wait_drain("abort", 20);
    chk("abort_pulses", 128'(abort_count), 1);
    chk("abort_pops", 128'(pop_count), 5);
    go_idle("abort");

    // Reset mid-burst on ch1 with a word held in the output register
    load(1, 6, 0, 6);
    expect_words(1, 6, 0, 1, 1'b0);
    pop_count = 0;
    enable = 1'b1;
    wait_pops("rstmid_pre", 2, 10);
    chk("rstmid_valid_before", 128'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("rstmid_out_valid", 128'(out_valid), 0);
    chk("rstmid_out_data", 128'(out_data), 0);
    chk("rstmid_out_ch", 128'(out_ch), 0);
    chk("rstmid_out_last", 128'(out_last), 0);
    chk("rstmid_busy", 128'(busy), 0);
    chk("rstmid_abort", 128'(burst_abort), 0);
    chk("rstmid_ack", 128'(fifo_ack), 0);
    repeat (3) tick();
    chk("rstmid_no_pops", 128'(pop_count), 2);
    load(0, 6, 0, 2);
    expect_words(0, 6, 0, 2, 1'b1);
    expect_words(1, 6, 2, 4, 1'b1);
    rst = 1'b0;
    begin
      int n = 0;
      ack_s = '0;
      while (ack_s == '0 && n < 10) begin
        tick();
        n++;
      end
    end
    chk("rstmid_first_grant", 128'(ack_s), 128'(4'b0001));
    wait_drain("rstmid", 20);
    go_idle("rstmid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ref_fifo_drain_arbiter.md
# ref_fifo_drain_arbiter

Round-robin drain scheduler for NUM_CH dual-clock FIFO read sides, all in the read clock domain. It grants one FIFO at a time and pops a burst of up to MAX_BURST words from it. The words go into a single registered valid/ready output stream tagged with channel number and end-of-burst. It sits between the per-source ref_dc_fifo instances and the shared DMA/packet engine. All FIFOs are built with EN_LOOK_AHEAD=1, so fifo_data is valid whenever fifo_empty=0 and an ack pops the word in the same cycle.

## Interface
- NUM_CH, 4: number of FIFO channels (2..16).
- CH_WIDTH, 2: width of channel index; equals ceil(log2(NUM_CH)).
- DATA_WIDTH, 72: FIFO word width.
- LEVEL_WIDTH, 8: FIFO rd_level width (FIFO ADDR_WIDTH+1).
- MAX_BURST, 16: maximum words per grant (1..2^BURST_WIDTH-1).
- BURST_WIDTH, 5: burst counter width.

Ports:
- clk  in  1  rising-edge clock (FIFO rd_clk domain).
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  allows new arbitration rounds.
- ch_mask  in  NUM_CH  per-channel eligibility; 1 = eligible.
- fifo_empty  in  NUM_CH  per-channel rd_empty.
- fifo_level  in  NUM_CH*LEVEL_WIDTH  per-channel rd_level; channel i uses bits [i*LEVEL_WIDTH +: LEVEL_WIDTH].
- fifo_data  in  NUM_CH*DATA_WIDTH  per-channel rd_data; same packing as fifo_level.
- fifo_ack  out  NUM_CH  per-channel rd_ack, combinational, one-hot or zero.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  output word.
- out_ch  out  CH_WIDTH  source channel of out_data.
- out_last  out  1  final word of the current burst.
- busy  out  1  state != IDLE.
- burst_abort  out  1  one-cycle pulse; granted FIFO went empty mid-burst.

## Operation
- States:
  - IDLE→ARB when enable=1.
  - ARB→XFER when a channel is found.
  - ARB→IDLE when enable=0.
  - XFER→ARB when the burst ends (IDLE if enable=0 at that point).
- ARB:
  - Request vector req = ~fifo_empty & ch_mask.
  - Search starts at channel (last_grant+1) mod NUM_CH and wraps; first set bit wins.
  - On a win: grant<=winner, last_grant<=winner, burst_len<=min(fifo_level[winner], MAX_BURST), cnt<=0.
  - If req=0, stay in ARB (or go to IDLE when enable=0).
- XFER:
  - pop = ~fifo_empty[grant] & (~out_valid | out_ready).
  - fifo_ack[grant]=pop; all other ack bits are 0. fifo_ack=0 in IDLE and ARB.
  - Each pop: cnt<=cnt+1.
  - Each pop loads the output register: out_valid<=1, out_data<=fifo_data[grant], out_ch<=grant, out_last<=(cnt==burst_len-1).
  - Pop with cnt==burst_len-1 ends the burst: next state ARB, or IDLE if enable=0.
  - Granted fifo_empty=1 in XFER (external flush/clr) aborts the burst:
    - burst_abort=1 for one cycle; next state ARB/IDLE.
    - No word is popped and no out_last is generated for that burst.
- Output register, when no pop: out_ready=1 clears out_valid; otherwise the register holds (data, ch and last stable while out_valid=1 and out_ready=0).
- enable deassert mid-burst: the current burst completes; then IDLE.
- ch_mask changes: sampled only in ARB; no effect on an active burst.
- burst_len: fifo_level is nonzero whenever fifo_empty=0, so burst_len ≥ 1. The read-side level only decreases through this block's own pops, so burst_len words are always available unless an abort occurs.
- Reset values:
  - state=IDLE, last_grant=NUM_CH-1 (channel 0 first), grant=0, cnt=0, burst_len=0.
  - out_valid=0, out_data=0, out_ch=0, out_last=0, burst_abort=0, busy=0.
  - fifo_ack=0 (combinationally, since state=IDLE).
- rst asserted mid-burst: all state returns to reset values immediately. A word held in the output register is discarded. No ack is issued while rst=1.

## Timing
- Arbitration costs one ARB cycle per burst. The first pop occurs in the first XFER cycle.
- Sustained throughput is 1 word/clk during a burst while out_ready=1.
- Gap between bursts is one cycle with no pop (the ARB cycle).
- Latency is 1 clk from a FIFO pop to out_valid.
- Backpressure: with out_valid=1 and out_ready=0, pop=0 and fifo_ack=0. Pops resume in the same cycle out_ready returns to 1.
- fifo_ack depends combinationally on out_ready, out_valid, fifo_empty and registered state. There are no combinational paths from fifo_data or fifo_level to any output.

## Test plan
- Round-robin order: ch0..ch3 each hold 3 words, mask=4'hF, out_ready=1.
  - Output bursts ch0,ch1,ch2,ch3, each 3 words; out_last on every third word.
  - One idle cycle between bursts.
  - 12 words total in 16 cycles after the first ARB.
- Burst cap: ch2 holds 40 words, other channels empty, MAX_BURST=16.
  - Bursts of 16, 16 and 8 words, all on ch2.
  - out_last on words 16, 32 and 40.
  - ARB cycle between each burst.
- Backpressure: during a burst, out_ready=0 for 5 cycles.
  - fifo_ack=0 for those cycles; out_data/out_ch/out_last stable.
  - No word lost or duplicated; FIFO contents appear in order.
- Mask and enable: mask=4'b1010 with all channels non-empty.
  - Only ch1 and ch3 are served.
  - Dropping enable mid-burst on ch3: the burst completes, then busy=0 and fifo_ack stays 0.
- Abort: ch0 granted with burst_len=8; force fifo_empty[0]=1 after 3 pops.
  - burst_abort pulses once; exactly 3 words are output with no out_last.
  - Arbiter moves on to ch1.
- Reset mid-burst: assert rst during a ch1 burst with out_valid=1.
  - All outputs reset immediately and fifo_ack=0.
  - After release with data in ch0 and ch1, ch0 is granted first.
